alu_arith_sequencer: RTL and testbench

//  Command-side front end for the 16-bit signed arithmetic unit. Accepts one
//  op (A, B, ALU_FUN) per valid/ready handshake, drives the unit's operand and

---
 rtl/alu_arith_sequencer_if.sv | 30 +++
 rtl/alu_arith_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_arith_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arith_sequencer_if.sv
// Command/response bundle between the control path and the arithmetic sequencer.
// Latency: none, wires only.
// Backpressure: cmd side is valid/ready; res side is valid/ready with payload held while res_ready is low.
interface alu_arith_sequencer_if #(
    parameter int WIDTH_AB   = 16,
    parameter int WIDTH_ARTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [WIDTH_AB-1:0]   cmd_a;
    logic [WIDTH_AB-1:0]   cmd_b;
    logic [3:0]            cmd_fun;

    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH_ARTH-1:0] res_data;
    logic                  res_carry;
    logic [1:0]            res_err;

    // master = control path issuing ops; slave = the sequencer
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_err
    );
endinterface

// File: rtl/alu_arith_sequencer.sv
// Front end for the 16-bit signed arithmetic unit; optional divide-by-zero guard via ALU_SEQ_DIV0_GUARD_EN.
// Latency: accept in cycle N -> res_valid in N+3 (N+1 for rejected ops, N+2+TIMEOUT on timeout).
// Backpressure: one op in flight; cmd_ready low from accept until the cycle after the response handshake.
module alu_arith_sequencer #(
    parameter int WIDTH_AB   = 16,
    parameter int WIDTH_ARTH = 32,
    parameter int TIMEOUT    = 4
) (
    input  logic                   clock,
    input  logic                   rest,
    alu_arith_sequencer_if.slave   cmd_res,
    output logic [WIDTH_AB-1:0]    alu_a,
    output logic [WIDTH_AB-1:0]    alu_b,
    output logic [3:0]             alu_fun,
    output logic                   arth_enable,
    input  logic                   arth_flag,
    input  logic                   carry_out,
    input  logic [WIDTH_ARTH-1:0]  Arthmtic_out,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_CLASS = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;
    localparam logic [3:0] CNT_LAST  = 4'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [3:0]              wait_cnt, wait_cnt_nxt;
    logic [WIDTH_AB-1:0]     alu_a_nxt, alu_b_nxt;
    logic [3:0]              alu_fun_nxt;
    logic                    arth_enable_nxt;
    logic                    cmd_ready_q, cmd_ready_nxt;
    logic                    res_valid_q, res_valid_nxt;
    logic [WIDTH_ARTH-1:0]   res_data_q, res_data_nxt;
    logic                    res_carry_q, res_carry_nxt;
    logic [1:0]              res_err_q, res_err_nxt;

    always_ff @(posedge clock) begin
        if (rest) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_fun     <= '0;
            arth_enable <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            alu_a       <= alu_a_nxt;
            alu_b       <= alu_b_nxt;
            alu_fun     <= alu_fun_nxt;
            arth_enable <= arth_enable_nxt;
            cmd_ready_q <= cmd_ready_nxt;
            res_valid_q <= res_valid_nxt;
            res_data_q  <= res_data_nxt;
            res_carry_q <= res_carry_nxt;
            res_err_q   <= res_err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        alu_a_nxt       = alu_a;
        alu_b_nxt       = alu_b;
        alu_fun_nxt     = alu_fun;
        arth_enable_nxt = 1'b0;
        cmd_ready_nxt   = 1'b0;
        res_valid_nxt   = res_valid_q;
        res_data_nxt    = res_data_q;
        res_carry_nxt   = res_carry_q;
        res_err_nxt     = res_err_q;

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_res.cmd_valid && cmd_ready_q) begin
                    alu_a_nxt     = cmd_res.cmd_a;
                    alu_b_nxt     = cmd_res.cmd_b;
                    alu_fun_nxt   = cmd_res.cmd_fun;
                    cmd_ready_nxt = 1'b0;
                    if (cmd_res.cmd_fun[3:2] != 2'b00) begin
                        // non-arithmetic class never reaches the unit
                        state_nxt     = RESP;
                        res_valid_nxt = 1'b1;
                        res_data_nxt  = '0;
                        res_carry_nxt = 1'b0;
                        res_err_nxt   = ERR_CLASS;
                    end
`ifdef ALU_SEQ_DIV0_GUARD_EN
                    else if (cmd_res.cmd_fun == 4'b0011 && cmd_res.cmd_b == '0) begin
                        state_nxt     = RESP;
                        res_valid_nxt = 1'b1;
                        res_data_nxt  = '0;
                        res_carry_nxt = 1'b0;
                        res_err_nxt   = 2'b01;
                    end
`endif
                    else begin
                        state_nxt       = ISSUE;
                        arth_enable_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt    = WAIT;
                wait_cnt_nxt = '0;
            end
            WAIT: begin
                if (arth_flag) begin
                    state_nxt     = RESP;
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = Arthmtic_out;
                    res_carry_nxt = carry_out;
                    res_err_nxt   = ERR_OK;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt     = RESP;
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = '0;
                    res_carry_nxt = 1'b0;
                    res_err_nxt   = ERR_TMO;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            RESP: begin
                // payload stays frozen; only the handshake moves us on
                if (cmd_res.res_ready) begin
                    state_nxt     = IDLE;
                    res_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_res.cmd_ready = cmd_ready_q;
    assign cmd_res.res_valid = res_valid_q;
    assign cmd_res.res_data  = res_data_q;
    assign cmd_res.res_carry = res_carry_q;
    assign cmd_res.res_err   = res_err_q;
    assign busy              = (state != IDLE);

endmodule

// File: tb/tb_alu_arith_sequencer.sv
// Bench for alu_arith_sequencer: transaction-level model plus a behavioural stand-in for the arithmetic unit.
module tb_alu_arith_sequencer;
    localparam int TMO = 4;
`ifdef ALU_SEQ_DIV0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rest  = 1'b1;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        arth_enable, busy;
    logic        arth_flag = 1'b0;
    logic        carry_out = 1'b0;
    logic [31:0] Arthmtic_out = '0;

    alu_arith_sequencer_if #(.WIDTH_AB(16), .WIDTH_ARTH(32)) sif ();

    alu_arith_sequencer #(.WIDTH_AB(16), .WIDTH_ARTH(32), .TIMEOUT(TMO)) dut (
        .clock        (clock),
        .rest         (rest),
        .cmd_res      (sif),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_fun      (alu_fun),
        .arth_enable  (arth_enable),
        .arth_flag    (arth_flag),
        .carry_out    (carry_out),
        .Arthmtic_out (Arthmtic_out),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // transaction model state
    bit          have_txn = 0;
    int          acc_cyc, en_cyc, resp_cyc, first_vld;
    logic [1:0]  e_err;
    logic [31:0] e_data;
    logic        e_carry;
    bit          chk_data;
    logic [15:0] la = '0, lb = '0;
    logic [3:0]  lf = '0;
    bit          post_rst = 1;
    bit          en_seen = 0;

    // unit stand-in
    logic [31:0] u_res;
    logic        u_carry;
    int          u_delay = -1;
    int          ucnt = 0;

    // stimulus request and response record
    bit          want_cmd = 0;
    logic [3:0]  w_fun;
    logic [15:0] w_a, w_b;
    int          w_d;
    int          rr_hold = 0;
    bit          rr_random = 0;
    bit          got = 0;
    logic [31:0] got_data;
    logic [1:0]  got_err;
    int          got_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (f)
            4'd0:    return 32'(sa + sb);
            4'd1:    return 32'(sa - sb);
            4'd2:    return 32'(sa * sb);
            4'd3:    return (sb == 0) ? 32'd0 : 32'(sa / sb);
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input bit do_rst);
        bit idle_now;
        @(negedge clock);
        // ---- compare DUT against the model
        if (post_rst) begin
            chk("rst_res_data", sif.res_data, 0);
            chk("rst_res_err", 32'(sif.res_err), 0);
            chk("rst_res_carry", 32'(sif.res_carry), 0);
            post_rst = 0;
        end
        chk("alu_a_hold", 32'(alu_a), 32'(la));
        chk("alu_b_hold", 32'(alu_b), 32'(lb));
        chk("alu_fun_hold", 32'(alu_fun), 32'(lf));
        if (!have_txn) begin
            chk("idle_res_valid", 32'(sif.res_valid), 0);
            chk("idle_cmd_ready", 32'(sif.cmd_ready), 1);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_arth_enable", 32'(arth_enable), 0);
        end else begin
            chk("busy_cmd_ready", 32'(sif.cmd_ready), 0);
            chk("busy_busy", 32'(busy), 1);
            chk("arth_enable", 32'(arth_enable), 32'(cyc == en_cyc));
            if (arth_enable === 1'b1) en_seen = 1;
            if (sif.res_valid === 1'b1 && first_vld < 0) first_vld = cyc;
            if (cyc < resp_cyc) begin
                chk("res_valid_early", 32'(sif.res_valid), 0);
            end else begin
                chk("res_valid", 32'(sif.res_valid), 1);
                chk("res_err", 32'(sif.res_err), 32'(e_err));
                chk("res_carry", 32'(sif.res_carry), 32'(e_carry));
                if (chk_data) chk("res_data", sif.res_data, e_data);
            end
        end

        // ---- drive next cycle
        idle_now  = !have_txn;
        arth_flag = 1'b0;
        Arthmtic_out = $urandom;
        carry_out = 1'($urandom);
        if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) begin
                arth_flag    = 1'b1;
                Arthmtic_out = u_res;
                carry_out    = u_carry;
            end
        end
        if (arth_enable === 1'b1 && u_delay >= 0) ucnt = u_delay + 1;

        if (have_txn && cyc >= resp_cyc) begin
            if (rr_hold > 0) begin
                sif.res_ready = 1'b0;
                rr_hold--;
            end else if (rr_random) begin
                sif.res_ready = 1'($urandom_range(0, 1));
            end else begin
                sif.res_ready = 1'b1;
            end
            if (sif.res_ready && !do_rst) begin
                got      = 1;
                got_data = sif.res_data;
                got_err  = sif.res_err;
                got_lat  = first_vld - acc_cyc;
                have_txn = 0;
            end
        end else begin
            sif.res_ready = 1'($urandom_range(0, 1));
        end

        if (idle_now && want_cmd && !do_rst) begin
            sif.cmd_valid = 1'b1;
            sif.cmd_a     = w_a;
            sif.cmd_b     = w_b;
            sif.cmd_fun   = w_fun;
            have_txn  = 1;
            want_cmd  = 0;
            acc_cyc   = cyc;
            first_vld = -1;
            la = w_a; lb = w_b; lf = w_fun;
            chk_data = 1; e_data = '0; e_carry = 1'b0; en_cyc = -1; u_delay = -1;
            if (w_fun[3:2] != 2'b00) begin
                e_err = 2'b10; resp_cyc = cyc + 1;
            end else if (GUARD && w_fun == 4'd3 && w_b == 16'd0) begin
                e_err = 2'b01; resp_cyc = cyc + 1;
            end else begin
                en_cyc  = cyc + 1;
                u_res   = alu_ref(w_fun, w_a, w_b);
                u_carry = 1'($urandom);
                u_delay = w_d;
                if (w_d >= 0 && w_d < TMO) begin
                    e_err = 2'b00; e_data = u_res; e_carry = u_carry;
                    resp_cyc = cyc + 3 + w_d;
                    chk_data = !(w_fun == 4'd3 && w_b == 16'd0);
                end else begin
                    e_err = 2'b11; resp_cyc = cyc + 2 + TMO;
                end
            end
        end else begin
            sif.cmd_valid = idle_now ? 1'b0 : 1'($urandom_range(0, 2) == 0);
            sif.cmd_a     = 16'($urandom);
            sif.cmd_b     = 16'($urandom);
            sif.cmd_fun   = 4'($urandom);
        end

        rest = do_rst;
        if (do_rst) begin
            have_txn = 0; want_cmd = 0; la = '0; lb = '0; lf = '0;
            ucnt = 0; arth_flag = 1'b0; post_rst = 1;
        end
    endtask

    task automatic run_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input int d, input int hold, input bit rnd);
        w_fun = f; w_a = a; w_b = b; w_d = d;
        rr_hold = hold; rr_random = rnd;
        got = 0; en_seen = 0; want_cmd = 1;
        for (int k = 0; k < 200 && !got; k++) step(1'b0);
        if (!got) chk("op_completion", 0, 1);
    endtask

    initial begin
        sif.cmd_valid = 1'b0; sif.cmd_a = '0; sif.cmd_b = '0; sif.cmd_fun = '0;
        sif.res_ready = 1'b0;
        step(1'b1);
        step(1'b1);
        step(1'b0);

        run_op(4'b0000, 16'd100, -16'sd30, 0, 0, 0);
        chk("add_data", got_data, 32'd70);
        chk("add_err", 32'(got_err), 0);
        chk("add_latency", 32'(got_lat), 3);

        run_op(4'b0010, -16'sd300, 16'd200, 0, 5, 0);
        chk("mul_data", got_data, 32'hFFFF15A0);
        chk("mul_latency", 32'(got_lat), 3);

        run_op(4'b0100, 16'd7, 16'd9, 0, 0, 0);
        chk("class_err", 32'(got_err), 2);
        chk("class_data", got_data, 0);
        chk("class_enable_seen", 32'(en_seen), 0);
        chk("class_latency", 32'(got_lat), 1);

        run_op(4'b0011, 16'd1234, 16'd0, 0, 0, 0);
`ifdef ALU_SEQ_DIV0_GUARD_EN
        chk("div0_err", 32'(got_err), 1);
        chk("div0_latency", 32'(got_lat), 1);
        chk("div0_enable_seen", 32'(en_seen), 0);
        chk("div0_data", got_data, 0);
`else
        chk("div0_err", 32'(got_err), 0);
        chk("div0_latency", 32'(got_lat), 3);
        chk("div0_enable_seen", 32'(en_seen), 1);
`endif

        run_op(4'b0001, 16'd5, 16'd3, -1, 0, 0);
        chk("timeout_err", 32'(got_err), 3);
        chk("timeout_latency", 32'(got_lat), 2 + TMO);
        chk("timeout_data", got_data, 0);

        // reset while the unit is being waited on
        w_fun = 4'b0000; w_a = 16'd1; w_b = 16'd2; w_d = -1; want_cmd = 1;
        for (int k = 0; k < 20; k++) begin
            if (have_txn && cyc == acc_cyc + 2) break;
            step(1'b0);
        end
        chk("rst_wait_reached", 32'(have_txn && cyc == acc_cyc + 2), 1);
        step(1'b1);
        for (int k = 0; k < 8; k++) step(1'b0);

        for (int n = 0; n < 250; n++) begin
            logic [3:0]  f;
            logic [15:0] b;
            int          d;
            f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
            case ($urandom_range(0, 5))
                0, 1, 2: d = 0;
                3, 4:    d = $urandom_range(0, TMO + 1);
                default: d = -1;
            endcase
            run_op(f, 16'($urandom), b, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
